// File: rtl/ex_pkg.sv
// ex_pkg: shared definitions for the execute stage.
// Holds the id_divop bit positions, the divider state encoding, the
// divide-by-zero constants and the one-hot ALU opcode bit positions.
`timescale 1ns/1ps
package ex_pkg;

   // id_divop field layout
   localparam int DIVOP_W      = 3;
   localparam int DIVOP_IS_DIV = 2;   // divide-class operation
   localparam int DIVOP_SIGNED = 1;   // signed operands
   localparam int DIVOP_REM    = 0;   // 1 = remainder, 0 = quotient

   // Iterative divider states
   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_BUSY = 2'd1,
      DIV_DONE = 2'd2
   } div_state_e;

   // Divide by zero: the quotient is all ones (sliced to the datapath
   // width) and the remainder is the original dividend.
   localparam logic [63:0] DIV0_QUOTIENT_FILL   = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam bit          DIV0_REM_IS_DIVIDEND = 1'b1;

   // One-hot ALU opcode bit positions
   localparam int ALU_ADD    = 0;
   localparam int ALU_SUB    = 1;
   localparam int ALU_SLT    = 2;
   localparam int ALU_SLTU   = 3;
   localparam int ALU_AND    = 4;
   localparam int ALU_NOR    = 5;
   localparam int ALU_OR     = 6;
   localparam int ALU_XOR    = 7;
   localparam int ALU_SLL    = 8;
   localparam int ALU_SRL    = 9;
   localparam int ALU_SRA    = 10;
   localparam int ALU_LUI    = 11;
   localparam int ALU_OP_NUM = 12;

endpackage

// File: rtl/alu.sv
// alu: single-cycle ALU with a one-hot opcode. Purely combinational.
`timescale 1ns/1ps
module alu
   import ex_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int ALUOP_W = 12
)(
   input  logic [ALUOP_W-1:0] alu_op,
   input  logic [DATA_W-1:0]  alu_src1,
   input  logic [DATA_W-1:0]  alu_src2,
   output logic [DATA_W-1:0]  alu_result
);

   localparam int SH_W = $clog2(DATA_W);

   logic [SH_W-1:0] shamt;
   assign shamt = alu_src2[SH_W-1:0];

   // OR together the result of whichever single operation is selected
   always_comb begin
      alu_result = '0;
      if (alu_op[ALU_ADD])  alu_result |= alu_src1 + alu_src2;
      if (alu_op[ALU_SUB])  alu_result |= alu_src1 - alu_src2;
      if (alu_op[ALU_SLT])  alu_result |= {{(DATA_W-1){1'b0}}, ($signed(alu_src1) < $signed(alu_src2))};
      if (alu_op[ALU_SLTU]) alu_result |= {{(DATA_W-1){1'b0}}, (alu_src1 < alu_src2)};
      if (alu_op[ALU_AND])  alu_result |= alu_src1 & alu_src2;
      if (alu_op[ALU_NOR])  alu_result |= ~(alu_src1 | alu_src2);
      if (alu_op[ALU_OR])   alu_result |= alu_src1 | alu_src2;
      if (alu_op[ALU_XOR])  alu_result |= alu_src1 ^ alu_src2;
      if (alu_op[ALU_SLL])  alu_result |= alu_src1 << shamt;
      if (alu_op[ALU_SRL])  alu_result |= alu_src1 >> shamt;
      if (alu_op[ALU_SRA])  alu_result |= DATA_W'($signed(alu_src1) >>> shamt);
      if (alu_op[ALU_LUI])  alu_result |= alu_src2;
   end

endmodule

// File: rtl/ex_div.sv
// ex_div: iterative restoring divider, one quotient bit per cycle.
// Operands are latched as absolute values on start; the result is
// sign-corrected combinationally from the held magnitudes.
`timescale 1ns/1ps
module ex_div
   import ex_pkg::*;
#(
   parameter int DATA_W = 32
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic              ack,
   input  logic              sign_op,
   input  logic [DATA_W-1:0] dividend,
   input  logic [DATA_W-1:0] divisor,
   output logic              done,
   output logic [DATA_W-1:0] quotient,
   output logic [DATA_W-1:0] remainder
);

   localparam int CNT_W = $clog2(DATA_W + 1);

   div_state_e        state_reg, state_next;
   logic [CNT_W-1:0]  cnt_reg;
   logic [DATA_W-1:0] quo_reg;       // dividend bits shift out, quotient bits shift in
   logic [DATA_W-1:0] rem_reg;       // partial remainder magnitude
   logic [DATA_W-1:0] divisor_reg;   // divisor magnitude
   logic [DATA_W-1:0] dividend_reg;  // original dividend for the divide-by-zero case
   logic              neg_quo_reg, neg_rem_reg, div0_reg;

   logic [DATA_W:0]   shifted, diff;
   logic [DATA_W-1:0] dividend_abs, divisor_abs;
   logic              last_step;

   assign last_step    = (cnt_reg == CNT_W'(DATA_W - 1));
   assign dividend_abs = (sign_op & dividend[DATA_W-1]) ? -dividend : dividend;
   assign divisor_abs  = (sign_op & divisor[DATA_W-1])  ? -divisor  : divisor;
   assign shifted      = {rem_reg, quo_reg[DATA_W-1]};
   assign diff         = shifted - {1'b0, divisor_reg};

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= DIV_IDLE;
      else        state_reg <= state_next;
   end

   // Next-state logic; abort wins from any state
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         DIV_IDLE: if (start)     state_next = DIV_BUSY;
         DIV_BUSY: if (last_step) state_next = DIV_DONE;
         DIV_DONE: if (ack)       state_next = DIV_IDLE;
         default:                 state_next = DIV_IDLE;
      endcase
      if (abort) state_next = DIV_IDLE;
   end

   // Operand latch on start, then one restoring step per BUSY cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg      <= '0;
         quo_reg      <= '0;
         rem_reg      <= '0;
         divisor_reg  <= '0;
         dividend_reg <= '0;
         neg_quo_reg  <= 1'b0;
         neg_rem_reg  <= 1'b0;
         div0_reg     <= 1'b0;
      end else if (state_reg == DIV_IDLE && start && !abort) begin
         cnt_reg      <= '0;
         quo_reg      <= dividend_abs;
         rem_reg      <= '0;
         divisor_reg  <= divisor_abs;
         dividend_reg <= dividend;
         neg_quo_reg  <= sign_op & (dividend[DATA_W-1] ^ divisor[DATA_W-1]);
         neg_rem_reg  <= sign_op & dividend[DATA_W-1];
         div0_reg     <= (divisor == '0);
      end else if (state_reg == DIV_BUSY && !abort) begin
         cnt_reg <= cnt_reg + 1'b1;
         if (!diff[DATA_W]) begin
            rem_reg <= diff[DATA_W-1:0];
            quo_reg <= {quo_reg[DATA_W-2:0], 1'b1};
         end else begin
            rem_reg <= shifted[DATA_W-1:0];
            quo_reg <= {quo_reg[DATA_W-2:0], 1'b0};
         end
      end
   end

   assign done      = (state_reg == DIV_DONE);
   assign quotient  = div0_reg ? DIV0_QUOTIENT_FILL[DATA_W-1:0]
                    : (neg_quo_reg ? -quo_reg : quo_reg);
   assign remainder = (div0_reg && DIV0_REM_IS_DIVIDEND) ? dividend_reg
                    : (neg_rem_reg ? -rem_reg : rem_reg);

endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage between ID and MEM with a valid/allowin
// handshake. Define EX_DIV_EN to build the iterative divider; without
// it, id_divop is ignored and every op completes in one cycle.
`timescale 1ns/1ps
module ex_stage
   import ex_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int SIDE_W  = 41,
   parameter int ALUOP_W = 12
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               id_valid,
   output logic               ex_allowin,
   input  logic [31:0]        id_pc,
   input  logic [31:0]        id_ir,
   input  logic [DATA_W-1:0]  id_src1,
   input  logic [DATA_W-1:0]  id_src2,
   input  logic [ALUOP_W-1:0] id_aluop,
   input  logic [2:0]         id_divop,
   input  logic [SIDE_W-1:0]  id_side,
   input  logic               flush,
   input  logic               mem_allowin,
   output logic               ex_to_mem_valid,
   output logic [31:0]        ex_pc,
   output logic [31:0]        ex_ir,
   output logic [SIDE_W-1:0]  ex_side,
   output logic [DATA_W-1:0]  ex_result
);

   logic               ex_valid_r;
   logic               ex_ready_go;
   logic               capture;
   logic               out_fire;
   logic [31:0]        pc_reg, ir_reg;
   logic [DATA_W-1:0]  src1_reg, src2_reg;
   logic [ALUOP_W-1:0] aluop_reg;
   logic [SIDE_W-1:0]  side_reg;
   logic [DATA_W-1:0]  alu_res;

   assign ex_allowin      = ~ex_valid_r | (ex_ready_go & mem_allowin);
   assign capture         = id_valid & ex_allowin & ~flush;
   assign ex_to_mem_valid = ex_valid_r & ex_ready_go & ~flush;
   assign out_fire        = ex_to_mem_valid & mem_allowin;

   // Stage occupancy: flush kills, capture refills, a lone fire empties
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        ex_valid_r <= 1'b0;
      else if (flush)    ex_valid_r <= 1'b0;
      else if (capture)  ex_valid_r <= 1'b1;
      else if (out_fire) ex_valid_r <= 1'b0;
   end

   // Stage payload register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_reg    <= '0;
         ir_reg    <= '0;
         src1_reg  <= '0;
         src2_reg  <= '0;
         aluop_reg <= '0;
         side_reg  <= '0;
      end else if (capture) begin
         pc_reg    <= id_pc;
         ir_reg    <= id_ir;
         src1_reg  <= id_src1;
         src2_reg  <= id_src2;
         aluop_reg <= id_aluop;
         side_reg  <= id_side;
      end
   end

   alu #(
      .DATA_W  (DATA_W),
      .ALUOP_W (ALUOP_W)
   ) u_alu (
      .alu_op     (aluop_reg),
      .alu_src1   (src1_reg),
      .alu_src2   (src2_reg),
      .alu_result (alu_res)
   );

`ifdef EX_DIV_EN
   logic [2:0]        divop_reg;
   logic              div_done;
   logic [DATA_W-1:0] div_quo, div_rem;

   // Divide opcode travels with the rest of the payload
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       divop_reg <= '0;
      else if (capture) divop_reg <= id_divop;
   end

   ex_div #(
      .DATA_W (DATA_W)
   ) u_div (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (ex_valid_r & divop_reg[DIVOP_IS_DIV]),
      .abort     (flush),
      .ack       (out_fire),
      .sign_op   (divop_reg[DIVOP_SIGNED]),
      .dividend  (src1_reg),
      .divisor   (src2_reg),
      .done      (div_done),
      .quotient  (div_quo),
      .remainder (div_rem)
   );

   assign ex_ready_go = ~divop_reg[DIVOP_IS_DIV] | div_done;
   assign ex_result   = divop_reg[DIVOP_IS_DIV]
                      ? (divop_reg[DIVOP_REM] ? div_rem : div_quo)
                      : alu_res;
`else
   logic unused_divop;
   assign unused_divop = ^id_divop;
   assign ex_ready_go  = 1'b1;
   assign ex_result    = alu_res;
`endif

   assign ex_pc   = pc_reg;
   assign ex_ir   = ir_reg;
   assign ex_side = side_reg;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed bench for ex_stage with a behavioural result
// model and an expected-transaction queue checked on every output fire.
`timescale 1ns/1ps
module tb_ex_stage;
   import ex_pkg::*;

   localparam int DATA_W  = 32;
   localparam int SIDE_W  = 41;
   localparam int ALUOP_W = 12;
`ifdef EX_DIV_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               id_valid = 1'b0;
   logic               ex_allowin;
   logic [31:0]        id_pc = '0, id_ir = '0;
   logic [DATA_W-1:0]  id_src1 = '0, id_src2 = '0;
   logic [ALUOP_W-1:0] id_aluop = '0;
   logic [2:0]         id_divop = '0;
   logic [SIDE_W-1:0]  id_side = '0;
   logic               flush = 1'b0;
   logic               mem_allowin = 1'b1;
   logic               ex_to_mem_valid;
   logic [31:0]        ex_pc, ex_ir;
   logic [SIDE_W-1:0]  ex_side;
   logic [DATA_W-1:0]  ex_result;

   ex_stage #(.DATA_W(DATA_W), .SIDE_W(SIDE_W), .ALUOP_W(ALUOP_W)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .ex_allowin(ex_allowin),
      .id_pc(id_pc), .id_ir(id_ir), .id_src1(id_src1), .id_src2(id_src2),
      .id_aluop(id_aluop), .id_divop(id_divop), .id_side(id_side),
      .flush(flush), .mem_allowin(mem_allowin), .ex_to_mem_valid(ex_to_mem_valid),
      .ex_pc(ex_pc), .ex_ir(ex_ir), .ex_side(ex_side), .ex_result(ex_result)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   logic [31:0] pc_ctr = 32'h0000_1000;

   typedef struct {
      logic [31:0]       pc;
      logic [31:0]       ir;
      logic [SIDE_W-1:0] side;
      logic [DATA_W-1:0] result;
   } exp_t;
   exp_t exp_q[$];

   typedef struct {
      int          op;
      logic [2:0]  divop;
      logic [31:0] a;
      logic [31:0] b;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   // What the stage must produce, straight from the arithmetic definition
   function automatic logic [DATA_W-1:0] model_calc(input int op, input logic [2:0] divop,
                                                    input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
      longint sa, sb;
      int sh;
      sh = int'(b % DATA_W);
      if (DIV_EN && divop[2]) begin
         if (b == '0) return divop[0] ? a : {DATA_W{1'b1}};
         if (divop[1]) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return divop[0] ? DATA_W'(sa % sb) : DATA_W'(sa / sb);
         end
         return divop[0] ? (a % b) : (a / b);
      end
      case (op)
         ALU_ADD:  return a + b;
         ALU_SUB:  return a - b;
         ALU_SLT:  return ($signed(a) < $signed(b)) ? 1 : 0;
         ALU_SLTU: return (a < b) ? 1 : 0;
         ALU_AND:  return a & b;
         ALU_NOR:  return ~(a | b);
         ALU_OR:   return a | b;
         ALU_XOR:  return a ^ b;
         ALU_SLL:  return a << sh;
         ALU_SRL:  return a >> sh;
         ALU_SRA:  return DATA_W'($signed(a) >>> sh);
         ALU_LUI:  return b;
         default:  return '0;
      endcase
   endfunction

   // Present one instruction, wait for capture, optionally wait for its result.
   // Called in the low clock phase, at least 1 time unit after the falling edge.
   task automatic issue(input int op, input logic [2:0] divop, input logic [31:0] a,
                        input logic [31:0] b, input bit expect_out);
      exp_t e;
      int   guard, lat, want_lat;
      id_valid = 1'b1;
      id_pc    = pc_ctr;
      id_ir    = 32'hA000_0000 ^ pc_ctr;
      id_src1  = a;
      id_src2  = b;
      id_aluop = '0;
      id_aluop[op] = 1'b1;
      id_divop = divop;
      id_side  = SIDE_W'({$urandom, $urandom});
      pc_ctr   = pc_ctr + 4;
      guard = 0;
      while (!ex_allowin && guard < 200) begin
         @(negedge clk); #1;
         guard++;
      end
      if (!ex_allowin) begin
         vectors++; miscompares++;
         $display("FAIL allowin_timeout: got ex_allowin=0 after %0d cycles, required 1", guard);
         id_valid = 1'b0;
         return;
      end
      e.pc = id_pc; e.ir = id_ir; e.side = id_side;
      e.result = model_calc(op, divop, a, b);
      @(posedge clk);
      if (expect_out) exp_q.push_back(e);
      @(negedge clk);
      id_valid = 1'b0;
      #1;
      if (!expect_out) return;
      lat = 0;
      while (!ex_to_mem_valid && lat < 200) begin
         @(negedge clk); #1;
         lat++;
      end
      want_lat = (DIV_EN && divop[2]) ? DATA_W + 1 : 0;
      check("latency", 64'(lat), 64'(want_lat));
   endtask

   // Scoreboard: every accepted result must match the next expected transaction
   initial begin
      exp_t e;
      forever begin
         @(negedge clk); #2;
         if (rst_n && ex_to_mem_valid && mem_allowin) begin
            if (exp_q.size() == 0) begin
               vectors++; miscompares++;
               $display("FAIL unexpected_fire: got result %0h at pc %0h, required no output", ex_result, ex_pc);
            end else begin
               e = exp_q.pop_front();
               $display("txn pc=%h ir=%h side=%h result=%h expected=%h", ex_pc, ex_ir, ex_side, ex_result, e.result);
               check("pc", 64'(ex_pc), 64'(e.pc));
               check("ir", 64'(ex_ir), 64'(e.ir));
               check("side", 64'(ex_side), 64'(e.side));
               check("result", 64'(ex_result), 64'(e.result));
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog");
   end

   vec_t tbl [14];

   initial begin
      logic [31:0] hold_pc, hold_res;

      tbl = '{
         '{ALU_SUB,  3'b000, 32'd3,          32'd10},
         '{ALU_SLT,  3'b000, 32'hFFFF_FFFF,  32'd1},
         '{ALU_SLTU, 3'b000, 32'hFFFF_FFFF,  32'd1},
         '{ALU_AND,  3'b000, 32'hF0F0_1234,  32'h0FF0_FFFF},
         '{ALU_NOR,  3'b000, 32'h0000_00FF,  32'h0F00_0000},
         '{ALU_OR,   3'b000, 32'h1200_0000,  32'h0000_0034},
         '{ALU_XOR,  3'b000, 32'hAAAA_5555,  32'hFFFF_0000},
         '{ALU_SLL,  3'b000, 32'd1,          32'd31},
         '{ALU_SRL,  3'b000, 32'h8000_0000,  32'd4},
         '{ALU_SRA,  3'b000, 32'h8000_0000,  32'd4},
         '{ALU_LUI,  3'b000, 32'd0,          32'hABCD_E000},
         '{ALU_ADD,  3'b100, 32'd1000,       32'd7},
         '{ALU_ADD,  3'b111, 32'd7,          32'hFFFF_FFFD},
         '{ALU_SUB,  3'b111, 32'hFFFF_FFF9,  32'd3}
      };

      // Reset state
      repeat (3) @(negedge clk);
      #1;
      check("rst_valid", 64'(ex_to_mem_valid), 64'd0);
      check("rst_allowin", 64'(ex_allowin), 64'd1);
      check("rst_result", 64'(ex_result), 64'd0);
      check("rst_pc", 64'(ex_pc), 64'd0);
      check("rst_side", 64'(ex_side), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk); #1;

      // ADD 5 + 7
      issue(ALU_ADD, 3'b000, 32'd5, 32'd7, 1'b1);
      check("add_result", 64'(ex_result), 64'd12);
      check("add_allowin", 64'(ex_allowin), 64'd1);

      // Signed -7 / 2 quotient then remainder, issued back to back
      issue(ALU_ADD, 3'b110, 32'hFFFF_FFF9, 32'd2, 1'b1);
      check("sdiv_quo", 64'(ex_result), DIV_EN ? 64'hFFFF_FFFD : 64'hFFFF_FFFB);
      issue(ALU_ADD, 3'b111, 32'hFFFF_FFF9, 32'd2, 1'b1);
      check("sdiv_rem", 64'(ex_result), DIV_EN ? 64'hFFFF_FFFF : 64'hFFFF_FFFB);

      // Unsigned 100 / 0
      issue(ALU_ADD, 3'b100, 32'd100, 32'd0, 1'b1);
      check("div0_quo", 64'(ex_result), DIV_EN ? 64'hFFFF_FFFF : 64'd100);
      issue(ALU_ADD, 3'b101, 32'd100, 32'd0, 1'b1);
      check("div0_rem", 64'(ex_result), 64'd100);

      // Signed overflow 0x80000000 / -1
      issue(ALU_ADD, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
      check("ovf_quo", 64'(ex_result), DIV_EN ? 64'h8000_0000 : 64'h7FFF_FFFF);
      issue(ALU_ADD, 3'b111, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
      check("ovf_rem", 64'(ex_result), DIV_EN ? 64'd0 : 64'h7FFF_FFFF);

      // Assorted ALU and divide vectors against the model
      foreach (tbl[i]) issue(tbl[i].op, tbl[i].divop, tbl[i].a, tbl[i].b, 1'b1);

      // Flush a divide in flight around BUSY cycle 10
      @(negedge clk);
      mem_allowin = 1'b0;
      #1;
      issue(ALU_ADD, 3'b110, 32'd12345, 32'd17, 1'b0);
      repeat (9) @(negedge clk);
      flush = 1'b1;
      #1;
      check("flush_valid_same", 64'(ex_to_mem_valid), 64'd0);
      @(negedge clk);
      flush = 1'b0;
      mem_allowin = 1'b1;
      #1;
      check("flush_valid_next", 64'(ex_to_mem_valid), 64'd0);
      check("flush_allowin", 64'(ex_allowin), 64'd1);
      issue(ALU_ADD, 3'b000, 32'd40, 32'd2, 1'b1);
      check("post_flush_add", 64'(ex_result), 64'd42);
      issue(ALU_ADD, 3'b100, 32'd81, 32'd9, 1'b1);
      check("post_flush_div", 64'(ex_result), DIV_EN ? 64'd9 : 64'd90);

      // MEM backpressure for 5 cycles on an ADD result
      @(negedge clk);
      mem_allowin = 1'b0;
      #1;
      issue(ALU_ADD, 3'b000, 32'd9, 32'd4, 1'b1);
      hold_pc  = ex_pc;
      hold_res = ex_result;
      check("bp_result", 64'(hold_res), 64'd13);
      for (int k = 0; k < 5; k++) begin
         check("bp_valid", 64'(ex_to_mem_valid), 64'd1);
         check("bp_allowin", 64'(ex_allowin), 64'd0);
         check("bp_hold_result", 64'(ex_result), 64'd13);
         check("bp_hold_pc", 64'(ex_pc), 64'(hold_pc));
         @(negedge clk); #1;
      end
      mem_allowin = 1'b1;
      #1;
      check("bp_release_allowin", 64'(ex_allowin), 64'd1);
      @(negedge clk); #1;
      check("bp_drained", 64'(ex_to_mem_valid), 64'd0);

      // Asynchronous reset in the middle of a divide
      mem_allowin = 1'b0;
      issue(ALU_ADD, 3'b100, 32'd777, 32'd5, 1'b0);
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("arst_valid", 64'(ex_to_mem_valid), 64'd0);
      check("arst_allowin", 64'(ex_allowin), 64'd1);
      check("arst_result", 64'(ex_result), 64'd0);
      check("arst_pc", 64'(ex_pc), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      mem_allowin = 1'b1;
      #1;
      issue(ALU_ADD, 3'b110, 32'hFFFF_FF9C, 32'd7, 1'b1);
      check("post_rst_div", 64'(ex_result), DIV_EN ? 64'hFFFF_FFF2 : 64'hFFFF_FFA3);

      repeat (3) @(negedge clk);
      check("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
